// File: rtl/microwire_responder.sv
`timescale 1ns/1ps
// microwire_responder
//   Microwire (93Cxx-style) serial EEPROM responder that fronts a simple
//   synchronous word memory. Every bus input is synchronised into sys_clk,
//   and the instruction is decoded one sampled bit at a time.
//
// Ports
//   sys_clk      system clock; all logic uses its rising edge
//   rst          synchronous, active-high reset
//   sck, cs, mosi  bus master serial clock, chip select and data in (async)
//   miso         serial data out; held at 0 whenever miso_oe is 0
//   miso_oe      data-out drive enable; high only while streaming read data
//   mem_addr     word address presented to the backing store
//   mem_rd_en    one-cycle read strobe; mem_rd_data is valid the next cycle
//   mem_rd_data  read data from the backing store
//   mem_wr_en    one-cycle write strobe, issued when cs falls after a write
//   mem_wr_data  write data gathered from the bus
//   wr_enabled   write-enable latch (EWEN sets it, EWDS clears it)
module microwire_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  wr_enabled
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 2);

    typedef enum logic [2:0] {IDLE, START, OPCODE, ADDR, READ, WRITE, IGNORE} state_t;

    state_t                state, state_next;
    logic                  sck_p0, sck_p1, sck_p2;
    logic                  cs_p0, cs_p1, cs_p2;
    logic                  mosi_p0, mosi_p1;
    logic                  sck_rise, cs_rise, cs_fall;
    logic [1:0]            settle_cnt;
    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  load_pending;
    logic                  miso_q;
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [DATA_WIDTH-1:0] shift_sr;
    logic                  addr_last;

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous value for edge detection
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            {sck_p0, sck_p1, sck_p2} <= 3'b000;
            {cs_p0, cs_p1, cs_p2}    <= 3'b000;
            {mosi_p0, mosi_p1}       <= 2'b00;
        end else begin
            {sck_p0, sck_p1, sck_p2} <= {sck, sck_p0, sck_p1};
            {cs_p0, cs_p1, cs_p2}    <= {cs, cs_p0, cs_p1};
            {mosi_p0, mosi_p1}       <= {mosi, mosi_p0};
        end
    end

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign addr_full = {addr_sr[ADDR_WIDTH-2:0], mosi_p1};
    assign addr_last = (bit_cnt == CNT_W'(ADDR_WIDTH - 1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (cs_fall && state != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (armed && cs_rise) state_next = START;
                START:  if (sck_rise && mosi_p1) state_next = OPCODE;
                OPCODE: if (sck_rise && bit_cnt == CNT_W'(1)) state_next = ADDR;
                ADDR: begin
                    if (sck_rise && addr_last) begin
                        case (opcode)
                            2'b10:   state_next = READ;
                            2'b01:   state_next = WRITE;
                            default: state_next = IGNORE;
                        endcase
                    end
                end
                WRITE:  if (sck_rise && bit_cnt == CNT_W'(DATA_WIDTH)) state_next = IGNORE;
                default: state_next = state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        miso_oe = (state == READ);
        miso    = miso_oe & miso_q;
    end

    // Control and strobes. A cs already high when reset releases must not look
    // like a fresh select, so cs edges are honoured only once cs has been seen
    // low after the synchronisers have settled.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            settle_cnt   <= 2'd0;
            armed        <= 1'b0;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            miso_q       <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            wr_enabled   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
        end else begin
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            load_pending <= mem_rd_en;
            if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
            if (settle_cnt == 2'd3 && !cs_p1) armed <= 1'b1;

            if (cs_fall) begin
                if (state == WRITE && bit_cnt == CNT_W'(DATA_WIDTH) && wr_enabled)
                    mem_wr_en <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    OPCODE: begin
                        if (sck_rise)
                            bit_cnt <= (bit_cnt == CNT_W'(1)) ? '0 : bit_cnt + CNT_W'(1);
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            if (addr_last) begin
                                bit_cnt <= '0;
                                case (opcode)
                                    2'b10: begin
                                        mem_addr  <= addr_full;
                                        mem_rd_en <= 1'b1;
                                        miso_q    <= 1'b0;
                                    end
                                    2'b01: mem_addr <= addr_full;
                                    2'b00: begin
                                        if (addr_full[ADDR_WIDTH-1 -: 2] == 2'b11)
                                            wr_enabled <= 1'b1;
                                        else if (addr_full[ADDR_WIDTH-1 -: 2] == 2'b00)
                                            wr_enabled <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    READ: begin
                        if (sck_rise) begin
                            miso_q <= shift_sr[DATA_WIDTH-1];
                            // Driving bit 0: prefetch the next word well before its MSB is due
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                bit_cnt   <= '0;
                                mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                                mem_rd_en <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WRITE: begin
                        if (sck_rise && bit_cnt != CNT_W'(DATA_WIDTH)) begin
                            mem_wr_data <= {mem_wr_data[DATA_WIDTH-2:0], mosi_p1};
                            bit_cnt     <= bit_cnt + CNT_W'(1);
                        end
                    end
                    IGNORE: ;
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

    // Instruction and read-data shift registers (data path, no reset)
    always_ff @(posedge sys_clk) begin
        if (state == OPCODE && sck_rise) opcode <= {opcode[0], mosi_p1};
        if (state == ADDR && sck_rise)   addr_sr <= addr_full;
        if (load_pending)
            shift_sr <= mem_rd_data;
        else if (state == READ && sck_rise)
            shift_sr <= {shift_sr[DATA_WIDTH-2:0], 1'b0};
    end

endmodule

// File: tb/tb_microwire_responder.sv
`timescale 1ns/1ps
module tb_microwire_responder;

    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int HALF = 8;   // sck half period in sys_clk cycles

    logic          sys_clk = 1'b0;
    logic          rst, sck, cs, mosi;
    logic          miso, miso_oe, mem_rd_en, mem_wr_en, wr_enabled;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] mem_wr_data;

    logic [DW-1:0]       mem [0:(1<<AW)-1];
    logic [AW-1:0]       rd_log[$];
    logic [AW+DW-1:0]    wr_log[$];
    int                  both_cnt = 0;
    int                  oe_viol  = 0;
    int                  n_checks = 0;
    int                  n_fail   = 0;
    logic                model_wen;

    always #5 sys_clk = ~sys_clk;

    microwire_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .sys_clk(sys_clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .wr_enabled(wr_enabled)
    );

    // Backing store: data appears the cycle after the read strobe
    always @(posedge sys_clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
        if (mem_wr_en) wr_log.push_back({mem_addr, mem_wr_data});
        if (mem_rd_en && mem_wr_en) both_cnt++;
    end

    always @(negedge sys_clk) if (!miso_oe && miso) oe_viol++;

    function automatic logic [31:0] exp_read(input int a, input int words);
        logic [31:0] v = '0;
        for (int w = 0; w < words; w++) v = (v << DW) | 32'(mem[(a + w) % (1 << AW)]);
        return v;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // One sck period: data set while low, DO sampled 3 sys_clk after the rising edge
    task automatic sclk_bit(input logic b, output logic so, output logic oe);
        sck = 1'b0; mosi = b;
        wait_n(HALF);
        sck = 1'b1;
        wait_n(3);
        so = miso; oe = miso_oe;
        wait_n(HALF - 3);
    endtask

    task automatic shift(input logic [31:0] val, input int n, output logic [31:0] got, output logic oe_last);
        logic b, o;
        got = '0; oe_last = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            sclk_bit(val[i], b, o);
            got = {got[30:0], b};
            oe_last = o;
        end
    endtask

    task automatic cs_on();
        cs = 1'b1; wait_n(4);
    endtask

    task automatic cs_off();
        sck = 1'b0; mosi = 1'b0; cs = 1'b0; wait_n(8);
    endtask

    task automatic send_hdr(input logic [1:0] op, input logic [AW-1:0] a, input int lead0,
                            output logic dummy, output logic oe);
        logic [31:0] got;
        if (lead0 > 0) shift(32'd0, lead0, got, oe);
        shift({20'd0, 1'b1, op, a}, 3 + AW, got, oe);
        dummy = got[0];
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input int nbits);
        logic dm, oe; logic [31:0] got;
        cs_on(); send_hdr(2'b01, a, 0, dm, oe); shift(d, nbits, got, oe); cs_off();
    endtask

    task automatic do_special(input logic [1:0] top);
        logic dm, oe;
        cs_on(); send_hdr(2'b00, {top, 7'h55}, 0, dm, oe); cs_off();
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; sck = 1'b0; mosi = 1'b0;
        wait_n(5);
        n_checks++;
        if ({miso, miso_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, wr_enabled} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got oe=%b miso=%b addr=%h rd=%b wr=%b wd=%h wen=%b, expected all 0",
                     miso_oe, miso, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, wr_enabled);
        end
        rst = 1'b0; wait_n(5);
    endtask

    task automatic test_read_basic();
        logic dm, oe; logic [31:0] got; int base, hits;
        mem[9'h0A5] = 8'h24; base = rd_log.size();
        cs_on(); send_hdr(2'b10, 9'h0A5, 0, dm, oe);
        n_checks++; if (dm !== 1'b0 || oe !== 1'b1) begin n_fail++;
            $display("FAIL read_dummy: got miso=%b oe=%b, expected 0/1", dm, oe); end
        shift(32'd0, 8, got, oe);
        n_checks++; if (got[7:0] !== 8'h24) begin n_fail++;
            $display("FAIL read_data: got %h, expected 24", got[7:0]); end
        cs_off();
        hits = 0;
        for (int i = base; i < rd_log.size(); i++) if (rd_log[i] == 9'h0A5) hits++;
        n_checks++; if (rd_log.size() <= base || rd_log[base] !== 9'h0A5 || hits != 1) begin n_fail++;
            $display("FAIL read_strobe: got %0d strobes at 0a5, expected exactly 1 first", hits); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++;
            $display("FAIL read_oe_release: got %b, expected 0", miso_oe); end
    endtask

    task automatic test_read_wrap();
        logic dm, oe; logic [31:0] got; int base;
        mem[9'h1FF] = 8'h5A; mem[9'h000] = 8'hC3; base = rd_log.size();
        cs_on(); send_hdr(2'b10, 9'h1FF, 0, dm, oe); shift(32'd0, 16, got, oe); cs_off();
        n_checks++; if (got[15:0] !== 16'h5AC3) begin n_fail++;
            $display("FAIL read_wrap_data: got %h, expected 5ac3", got[15:0]); end
        n_checks++; if (rd_log.size() < base + 2 || rd_log[base] !== 9'h1FF || rd_log[base+1] !== 9'h000) begin n_fail++;
            $display("FAIL read_wrap_addr: got %0d strobes, expected 1ff then 000", rd_log.size() - base); end
    endtask

    task automatic test_write_protect();
        int base;
        base = wr_log.size(); do_write(9'h010, 32'h81, 8);
        n_checks++; if (wr_log.size() != base) begin n_fail++;
            $display("FAIL wr_protected: got %0d writes, expected 0", wr_log.size() - base); end
        do_special(2'b11);
        n_checks++; if (wr_enabled !== 1'b1) begin n_fail++;
            $display("FAIL ewen: got wr_enabled=%b, expected 1", wr_enabled); end
        base = wr_log.size(); do_write(9'h010, 32'h81, 8);
        n_checks++; if (wr_log.size() != base + 1 || wr_log[base] !== {9'h010, 8'h81}) begin n_fail++;
            $display("FAIL wr_commit: got %0d writes, expected 1 of 010/81", wr_log.size() - base); end
        mem[9'h010] = 8'h81;
    endtask

    task automatic test_ewds_and_overrun();
        int base;
        do_special(2'b00);
        n_checks++; if (wr_enabled !== 1'b0) begin n_fail++;
            $display("FAIL ewds: got wr_enabled=%b, expected 0", wr_enabled); end
        base = wr_log.size(); do_write(9'h010, 32'h7E, 8);
        n_checks++; if (wr_log.size() != base) begin n_fail++;
            $display("FAIL wr_after_ewds: got %0d writes, expected 0", wr_log.size() - base); end
        do_special(2'b11); do_special(2'b01);
        n_checks++; if (wr_enabled !== 1'b1) begin n_fail++;
            $display("FAIL wral_ignored: got wr_enabled=%b, expected 1", wr_enabled); end
        base = wr_log.size(); do_write(9'h010, 32'h0FD, 9);
        n_checks++; if (wr_log.size() != base) begin n_fail++;
            $display("FAIL wr_9bits: got %0d writes, expected 0", wr_log.size() - base); end
    endtask

    task automatic test_abort();
        logic dm, oe; logic [31:0] got; int base;
        mem[9'h003] = 8'($urandom); base = rd_log.size();
        cs_on(); shift({24'd0, 3'b110, 5'b00000}, 8, got, oe); cs_off();
        n_checks++; if (rd_log.size() != base || miso_oe !== 1'b0) begin n_fail++;
            $display("FAIL abort: got %0d strobes oe=%b, expected 0/0", rd_log.size() - base, miso_oe); end
        cs_on(); send_hdr(2'b10, 9'h003, 0, dm, oe); shift(32'd0, 8, got, oe); cs_off();
        n_checks++; if (got[7:0] !== mem[9'h003]) begin n_fail++;
            $display("FAIL abort_reread: got %h, expected %h", got[7:0], mem[9'h003]); end
    endtask

    task automatic test_reset_mid_write();
        logic dm, oe; logic [31:0] got; int wbase, rbase;
        do_special(2'b11);
        wbase = wr_log.size();
        cs_on(); send_hdr(2'b01, 9'h0AA, 0, dm, oe); shift(32'h5, 4, got, oe);
        rst = 1'b1; wait_n(3); rst = 1'b0; wait_n(2);
        n_checks++;
        if ({miso, miso_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, wr_enabled} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_write: got oe=%b addr=%h wd=%h wen=%b, expected all 0",
                     miso_oe, mem_addr, mem_wr_data, wr_enabled);
        end
        // cs never dropped: a complete READ must be ignored until a fresh select
        rbase = rd_log.size();
        send_hdr(2'b10, 9'h003, 0, dm, oe); shift(32'd0, 4, got, oe);
        n_checks++; if (rd_log.size() != rbase || oe !== 1'b0) begin n_fail++;
            $display("FAIL no_fresh_cs: got %0d strobes oe=%b, expected 0/0", rd_log.size() - rbase, oe); end
        cs_off();
        n_checks++; if (wr_log.size() != wbase) begin n_fail++;
            $display("FAIL reset_no_write: got %0d writes, expected 0", wr_log.size() - wbase); end
        model_wen = 1'b0;
    endtask

    task automatic test_random();
        logic dm, oe; logic [31:0] got, d; logic [AW-1:0] a; int base, kind, words, nb, lead;
        logic [1:0] top;
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 2);
            a = AW'($urandom);
            if (kind == 0) begin
                words = $urandom_range(1, 3); lead = $urandom_range(0, 2);
                cs_on(); send_hdr(2'b10, a, lead, dm, oe); shift(32'd0, words * DW, got, oe); cs_off();
                n_checks++; if (got !== exp_read(int'(a), words)) begin n_fail++;
                    $display("FAIL rand_read: addr %h got %h, expected %h", a, got, exp_read(int'(a), words)); end
            end else if (kind == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? DW + 1 : DW; d = $urandom;
                base = wr_log.size(); do_write(a, d, nb);
                if (model_wen && nb == DW) begin
                    n_checks++; if (wr_log.size() != base + 1 || wr_log[base] !== {a, d[DW-1:0]}) begin n_fail++;
                        $display("FAIL rand_write: got %0d writes, expected 1 of %h/%h", wr_log.size() - base, a, d[DW-1:0]); end
                    mem[a] = d[DW-1:0];
                end else begin
                    n_checks++; if (wr_log.size() != base) begin n_fail++;
                        $display("FAIL rand_nowrite: got %0d writes, expected 0", wr_log.size() - base); end
                end
            end else begin
                top = 2'($urandom);
                do_special(top);
                if (top == 2'b11) model_wen = 1'b1;
                else if (top == 2'b00) model_wen = 1'b0;
                n_checks++; if (wr_enabled !== model_wen) begin n_fail++;
                    $display("FAIL rand_special: got wr_enabled=%b, expected %b", wr_enabled, model_wen); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        model_wen = 1'b0;
        test_reset();
        test_read_basic();
        test_read_wrap();
        test_write_protect();
        test_ewds_and_overrun();
        test_abort();
        test_reset_mid_write();
        test_random();
        n_checks++; if (both_cnt != 0) begin n_fail++;
            $display("FAIL strobe_overlap: got %0d, expected 0", both_cnt); end
        n_checks++; if (oe_viol != 0) begin n_fail++;
            $display("FAIL miso_idle: got %0d cycles with miso=1 while oe=0, expected 0", oe_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microwire_responder.md
MICROWIRE_RESPONDER -- requirements
Module: microwire_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning address bits per instruction.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per word.
REQ-003 SHALL have port sys_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sck  input  1  serial clock from bus master, asynchronous to sys_clk.
REQ-006 SHALL have port cs  input  1  chip select, active-high, asynchronous.
REQ-007 SHALL have port mosi  input  1  serial data in (DI), asynchronous.
REQ-008 SHALL have port miso  output  1  serial data out (DO).
REQ-009 SHALL have port miso_oe  output  1  DO drive enable; DO treated as high-Z when 0.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  word address to backing store.
REQ-011 SHALL have port mem_rd_en  output  1  one-cycle read strobe; mem_rd_data valid the following cycle.
REQ-012 SHALL have port mem_rd_data  input  DATA_WIDTH  read data.
REQ-013 SHALL have port mem_wr_en  output  1  one-cycle write strobe.
REQ-014 SHALL have port mem_wr_data  output  DATA_WIDTH  write data.
REQ-015 SHALL have port wr_enabled  output  1  state of write-enable latch.

Function
REQ-016 SHALL pass sck, cs, mosi through two-flop synchronizers; sck rising/falling edges detected from synchronized value; mosi sampled on synchronized sck rising edge.
REQ-017 SHALL implement states IDLE, START, OPCODE, ADDR, READ, WRITE, IGNORE.
REQ-018 IDLE: cs low; on cs rising -> START.
REQ-019 START: leading mosi=0 bits ignored; first sampled 1 -> OPCODE.
REQ-020 OPCODE: sample 2 bits MSB first -> ADDR.
REQ-021 ADDR: sample ADDR_WIDTH bits MSB first; on last bit dispatch by opcode: 10 READ, 01 WRITE, 00 special, 11 IGNORE.
REQ-022 READ entry: mem_addr <= sampled address, mem_rd_en pulsed same cycle, miso_oe=1, miso=0 (dummy bit).
REQ-023 READ: each sck rising edge drives next data bit MSB first onto miso, within 3 sys_clk of the physical edge; after bit 0, next rising edge drives MSB of next word.
REQ-024 Sequential read: on driving bit 0, mem_addr increments (wrap 2^ADDR_WIDTH-1 -> 0) and mem_rd_en pulses; next word latched into shift register before its MSB is required.
REQ-025 sck period SHALL be >= 8 sys_clk; shorter periods unsupported.
REQ-026 WRITE: sample DATA_WIDTH bits MSB first into mem_wr_data; further bits -> IGNORE (write discarded).
REQ-027 Write commit: on cs falling in WRITE with exactly DATA_WIDTH bits received and wr_enabled=1, pulse mem_wr_en one cycle with mem_addr = sampled address; otherwise no write.
REQ-028 Special opcode 00: address top two bits 11 sets wr_enabled (EWEN); 00 clears it (EWDS); 01/10 (WRAL/ERAL) ignored; all -> IGNORE.
REQ-029 IGNORE: miso_oe=0, no memory strobes, until cs falls.
REQ-030 cs falling in any state -> IDLE next cycle; miso_oe=0; partial instruction discarded; wr_enabled retained.
REQ-031 miso_oe SHALL be 1 only in READ; miso=0 whenever miso_oe=0.
REQ-032 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle.

Reset
REQ-033 On rst: state IDLE, miso=0, miso_oe=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0, wr_enabled=0, synchronizers cleared.
REQ-034 rst mid-instruction SHALL abort without write; after release, responder waits for a fresh cs rising edge.

Verification
REQ-035 READ addr 0x0A5, memory[0x0A5]=0x24, sck=16 sys_clk -> dummy 0 then 00100100 on miso, one mem_rd_en at address 0x0A5.
REQ-036 READ addr 0x1FF held for 16 data bits, memory[0x1FF]=0x5A, memory[0x000]=0xC3 -> miso 01011010 11000011, mem_addr wraps to 0x000.
REQ-037 WRITE 0x010 data 0x81 without prior EWEN -> no mem_wr_en; after EWEN (00 11xxxxxxx) repeat -> single mem_wr_en, mem_addr=0x010, mem_wr_data=0x81 on cs falling.
REQ-038 EWDS then WRITE 0x010 data 0x7E -> wr_enabled=0, no mem_wr_en; WRITE with 9 data bits while enabled -> no mem_wr_en.
REQ-039 cs dropped after 5 address bits of READ, then full READ 0x003 -> first aborted (no mem_rd_en, miso_oe=0), second returns memory[0x003].
REQ-040 rst asserted during WRITE data phase with EWEN set -> all outputs at reset values, wr_enabled=0, no mem_wr_en.
